out_align_shift: RTL
====================

Name: out_align_shift

Overview:
- Multi-lane output alignment delay line for the systolic PE array.
- Each lane delays partial-sum outputs by D = filter_size - number_of_columns accepted samples, so column groups of a folded filter line up before accumulation.
- Adds a valid/ready handshake, per-stage valid tracking, a flush state machine that drains held samples, and guarded configuration loads with error reporting.

Parameters:
- I_WIDTH, 8, integer bits per sample.
- F_WIDTH, 8, fractional bits per sample; DW = I_WIDTH+F_WIDTH.
- N, 3, maximum filter size; delay storage depth is N-1 stages per lane (N >= 2).
- LANES, 4, number of independent data lanes sharing one delay setting.
- NUM_COL_WIDTH, $clog2(N+1), width of the column-count and filter-size fields.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- out_align_shift_rst_i  in  1  reset, synchronous, active-high.
- cfg_ld_i  in  1  load new number_of_columns_i/filter_size_i.
- number_of_columns_i  in  NUM_COL_WIDTH  columns mapped for this filter.
- filter_size_i  in  NUM_COL_WIDTH  filter size, valid range 1..N.
- in_valid_i  in  1  sample present on in_data_i.
- in_ready_o  out  1  block accepts samples (state RUN).
- in_data_i  in  LANES*DW  signed samples; lane k at [k*DW +: DW].
- flush_i  in  1  drain request.
- out_valid_o  out  1  out_data_o holds an aligned sample.
- out_data_o  out  LANES*DW  aligned signed samples, same lane packing.
- number_of_columns_o  out  NUM_COL_WIDTH  active column count.
- filter_size_o  out  NUM_COL_WIDTH  active filter size.
- flush_done_o  out  1  one-cycle pulse when drain completes.
- cfg_err_o  out  1  one-cycle pulse when a cfg_ld_i is rejected.

Behaviour:
- Reset (synchronous, checked before everything else): state RUN, all data stages 0, all stage valid bits 0, number_of_columns_o=0, filter_size_o=0 (D=0), flush counter 0, flush_done_o=0, cfg_err_o=0. Reset mid-flush aborts with no done pulse.
- Storage: per lane stages s[0..N-2] of DW bits, plus one shared valid bit v[j] per stage.
- D = filter_size_o - number_of_columns_o, range 0..N-1; tap = s[D-1].
- Push = in_valid_i & in_ready_o. On a push:
  - s[j] <= s[j-1] for j>0; s[0] <= in_data_i.
  - v shifts the same way with v[0] <= 1.
  - With no push in RUN, storage holds.
- RUN outputs, combinational (zero added latency):
  - If D==0: out_valid_o = push, out_data_o = in_data_i.
  - If D>0: out_valid_o = push & v[D-1], out_data_o = tap.
  - out_data_o = 0 whenever out_valid_o = 0.
  - During fill, the first D pushes produce no output.
- in_ready_o = 1 in RUN, 0 in FLUSH; in_valid_i is ignored in FLUSH.
- FSM RUN -> FLUSH on flush_i, when D>0 and any v[0..D-1] is set:
  - If in_valid_i is also high that cycle, the sample is pushed first and included in the drain.
  - Flush counter loads D.
- FSM FLUSH:
  - Each cycle, shift with zero data and v[0] <= 0.
  - out_valid_o = v[D-1], out_data_o = tap (0 if invalid).
  - Counter decrements. On the cycle the counter reaches 1, flush_done_o is registered high for the next cycle, and the state returns to RUN with all v = 0.
- flush_i in RUN with D==0 or all v[0..D-1]==0: flush_done_o pulses the next cycle, state stays RUN. flush_i in FLUSH is ignored.
- Configuration load, evaluated every cycle cfg_ld_i=1. It is accepted only when all of the following hold:
  - state RUN, and all v==0 at the start of the cycle;
  - 1 <= filter_size_i <= N;
  - number_of_columns_i <= filter_size_i.
- Accepted load: registers update at the edge; a same-cycle push uses the old D.
- Rejected load: registers unchanged, cfg_err_o pulses high the next cycle.
- Stale data in s[] is never output, because output gating uses v.

Test Plan:
- Reset, load nc=1, fs=3 (D=2), push lane0 values 10,20,30,40 on consecutive cycles -> out_valid_o low for the first two pushes, then 10 with push 3 and 20 with push 4; in_ready_o stays 1.
- D=0 (nc=3, fs=3), push 0x1234 on lane2 -> out_valid_o and out_data_o lane2 = 0x1234 in the same cycle.
- D=2, push A,B, then flush_i -> in_ready_o=0 for 2 cycles, out_valid_o outputs A then B, flush_done_o pulses once, state back to RUN with storage empty.
- cfg_ld_i with fs=4 (N=3), or nc=3 with fs=2, or while v≠0 -> cfg_err_o pulses, number_of_columns_o and filter_size_o unchanged.
- Assert reset during FLUSH, then push -> no flush_done_o, all outputs at reset values, D=0 behaviour immediately.
- D=1, flush_i and in_valid_i in the same cycle with storage empty -> sample C pushed with out_valid_o=0, then FLUSH drains C in 1 cycle, then flush_done_o.

Source files
------------

// File: rtl/out_align_shift.sv
// -----------------------------------------------------------------------------
// out_align_shift
//
// Multi-lane output alignment delay line for the systolic PE array. Every lane
// delays its partial-sum samples by D = filter_size - number_of_columns
// accepted samples, so the column groups of a folded filter line up before
// they are accumulated. All lanes share one delay setting and one set of
// per-stage valid bits.
//
// Ports:
//   clk_i                  clock, all state changes on the rising edge
//   out_align_shift_rst_i  synchronous active-high reset
//   cfg_ld_i               request to load number_of_columns_i / filter_size_i
//   number_of_columns_i    columns mapped for this filter
//   filter_size_i          filter size, legal range 1..N
//   in_valid_i/in_ready_o  input handshake (ready only in RUN)
//   in_data_i              LANES signed samples, lane k at [k*DW +: DW]
//   flush_i                drain request
//   out_valid_o/out_data_o aligned samples, same lane packing, zero when idle
//   number_of_columns_o    active column count
//   filter_size_o          active filter size
//   flush_done_o           one-cycle pulse when a drain completes
//   cfg_err_o              one-cycle pulse when a configuration load is refused
// -----------------------------------------------------------------------------
module out_align_shift #(
    parameter int I_WIDTH       = 8,
    parameter int F_WIDTH       = 8,
    parameter int N             = 3,
    parameter int LANES         = 4,
    parameter int NUM_COL_WIDTH = $clog2(N + 1)
) (
    input  logic                                 clk_i,
    input  logic                                 out_align_shift_rst_i,
    input  logic                                 cfg_ld_i,
    input  logic [NUM_COL_WIDTH-1:0]             number_of_columns_i,
    input  logic [NUM_COL_WIDTH-1:0]             filter_size_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic [LANES*(I_WIDTH+F_WIDTH)-1:0]   in_data_i,
    input  logic                                 flush_i,
    output logic                                 out_valid_o,
    output logic [LANES*(I_WIDTH+F_WIDTH)-1:0]   out_data_o,
    output logic [NUM_COL_WIDTH-1:0]             number_of_columns_o,
    output logic [NUM_COL_WIDTH-1:0]             filter_size_o,
    output logic                                 flush_done_o,
    output logic                                 cfg_err_o
);

    localparam int DW = I_WIDTH + F_WIDTH;
    localparam int S  = N - 1;                  // delay stages per lane

    localparam logic [S-1:0]             V_ONE = S'(1);
    localparam logic [NUM_COL_WIDTH-1:0] C_ONE = NUM_COL_WIDTH'(1);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t                   state_reg, state_next;
    logic [S-1:0]             v_reg, v_next;
    logic [NUM_COL_WIDTH-1:0] nc_reg, fs_reg;
    logic [NUM_COL_WIDTH-1:0] cnt_reg, cnt_next;
    logic                     flush_done_reg, flush_done_next;
    logic                     cfg_err_reg;

    logic [NUM_COL_WIDTH-1:0] d;
    logic                     d_zero;
    logic                     push;
    logic                     shift;
    logic [S-1:0]             win_mask;         // stages 0..D-1
    logic [S-1:0]             tap_sel;          // one-hot stage D-1
    logic                     any_win;
    logic                     tap_valid;
    logic                     cfg_ok;

    assign d          = fs_reg - nc_reg;
    assign d_zero     = (d == '0);
    assign in_ready_o = (state_reg == RUN);
    assign push       = in_valid_i & in_ready_o;
    // The shift register advances on every accepted sample and on every
    // drain cycle (where zeros are shifted in).
    assign shift      = push | (state_reg == FLUSH);

    // Window and tap decode built from comparisons instead of a variable
    // index, so D values beyond the stage count never address outside v/s.
    generate
        for (genvar gi = 0; gi < S; gi++) begin : g_decode
            localparam logic [NUM_COL_WIDTH-1:0] GI  = NUM_COL_WIDTH'(gi);
            localparam logic [NUM_COL_WIDTH-1:0] GI1 = NUM_COL_WIDTH'(gi + 1);
            assign win_mask[gi] = (GI < d);
            assign tap_sel[gi]  = (d == GI1);
        end
    endgenerate

    assign any_win   = |(v_reg & win_mask);
    assign tap_valid = |(v_reg & tap_sel);

    // Configuration is only swapped while nothing is held, so a new D can
    // never reinterpret samples that were pushed under the old one.
    assign cfg_ok = (state_reg == RUN) && (v_reg == '0) &&
                    (filter_size_i != '0) &&
                    (32'(filter_size_i) <= N) &&
                    (number_of_columns_i <= filter_size_i);

    // -------------------------------------------------------------------------
    // FSM next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        v_next          = v_reg;
        cnt_next        = cnt_reg;
        flush_done_next = 1'b0;
        out_valid_o     = 1'b0;

        case (state_reg)
            RUN: begin
                if (push) begin
                    v_next      = (v_reg << 1) | V_ONE;
                    out_valid_o = d_zero ? 1'b1 : tap_valid;
                end
                if (flush_i) begin
                    // A sample pushed in the flush cycle lands in stage 0 and
                    // therefore counts as held data for the drain.
                    if (!d_zero && (any_win || push)) begin
                        state_next = FLUSH;
                        cnt_next   = d;
                    end else begin
                        flush_done_next = 1'b1;
                    end
                end
            end
            FLUSH: begin
                out_valid_o = tap_valid;
                v_next      = v_reg << 1;
                cnt_next    = cnt_reg - C_ONE;
                if (cnt_reg == C_ONE) begin
                    state_next      = RUN;
                    v_next          = '0;
                    flush_done_next = 1'b1;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (out_align_shift_rst_i) begin
            state_reg      <= RUN;
            v_reg          <= '0;
            cnt_reg        <= '0;
            nc_reg         <= '0;
            fs_reg         <= '0;
            flush_done_reg <= 1'b0;
            cfg_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            v_reg          <= v_next;
            cnt_reg        <= cnt_next;
            flush_done_reg <= flush_done_next;
            cfg_err_reg    <= cfg_ld_i & ~cfg_ok;
            if (cfg_ld_i && cfg_ok) begin
                nc_reg <= number_of_columns_i;
                fs_reg <= filter_size_i;
            end
        end
    end

    assign number_of_columns_o = nc_reg;
    assign filter_size_o       = fs_reg;
    assign flush_done_o        = flush_done_reg;
    assign cfg_err_o           = cfg_err_reg;

    // -------------------------------------------------------------------------
    // Per-lane data stages
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DW-1:0] s_reg [S];
            logic [DW-1:0] tap;
            logic [DW-1:0] lane_in;

            assign lane_in = in_data_i[gi*DW +: DW];

            always_ff @(posedge clk_i) begin
                if (out_align_shift_rst_i) begin
                    for (int j = 0; j < S; j++) begin
                        s_reg[j] <= '0;
                    end
                end else if (shift) begin
                    s_reg[0] <= push ? lane_in : '0;
                    for (int j = 1; j < S; j++) begin
                        s_reg[j] <= s_reg[j-1];
                    end
                end
            end

            always_comb begin
                tap = '0;
                for (int j = 0; j < S; j++) begin
                    if (tap_sel[j]) begin
                        tap = s_reg[j];
                    end
                end
            end

            // Gating on out_valid keeps stale stage contents off the output.
            assign out_data_o[gi*DW +: DW] = !out_valid_o ? '0 :
                                             (d_zero ? lane_in : tap);
        end
    endgenerate

endmodule
